// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: control, data and display signals of the seven-segment scan controller
interface seg_scan_ctrl_if;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [6:0]  seg_dec;
  logic [3:0]  bcd_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        pending;
  logic        frame_tick;
  modport slave (
    input  enable, load, digits_in, dp_in, lz_en, seg_dec,
    output bcd_out, seg_out, dp_out, an_out, pending, frame_tick
  );
  modport master (
    output enable, load, digits_in, dp_in, lz_en, seg_dec,
    input  bcd_out, seg_out, dp_out, an_out, pending, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed seven-segment scanner with blanking gap and frame-aligned double buffering
module seg_scan_ctrl #(
  parameter int DIV   = 1000,
  parameter int BLANK = 4
) (
  input logic           clk,
  input logic           rst,
  seg_scan_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_idx, w_idx_nx;
  logic [15:0] r_cnt, w_cnt_nx;
  logic [15:0] r_act_dig, r_pen_dig;
  logic [3:0]  r_act_dp, r_pen_dp;
  logic        r_act_lz, r_pen_lz, r_pending;
  logic [6:0]  r_seg;
  logic        r_dp, r_tick;
  logic [3:0]  r_an;
  logic        w_fstart, w_lit, w_tick, w_blank;
  logic [3:0]  w_digit, w_hz;
  assign w_digit = r_act_dig[{r_idx, 2'b00} +: 4];
  assign w_hz = {r_act_dig[15:12] == 4'd0, r_act_dig[15:8] == 8'd0, r_act_dig[15:4] == 12'd0, 1'b0};
  assign w_blank = r_act_lz & w_hz[r_idx];
  assign bus.bcd_out = r_state == S_IDLE ? 4'd0 : w_digit;
  assign bus.seg_out = r_seg;
  assign bus.dp_out = r_dp;
  assign bus.an_out = r_an;
  assign bus.pending = r_pending;
  assign bus.frame_tick = r_tick;
  // next state, slot counter/index and the frame-start / slot-lit / wrap events
  always_comb begin
    w_next = r_state;
    w_cnt_nx = r_cnt + 16'd1;
    w_idx_nx = r_idx;
    w_fstart = 1'b0;
    w_lit = 1'b0;
    w_tick = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = 16'd0;
        w_next = bus.enable ? S_BLANK : S_IDLE;
        w_fstart = bus.enable;
      end
      S_BLANK: begin
        w_lit = r_cnt == 16'(BLANK - 1);
        w_next = w_lit ? S_SHOW : S_BLANK;
      end
      default: if (r_cnt == 16'(DIV - 1)) begin
        w_next = S_BLANK;
        w_cnt_nx = 16'd0;
        w_idx_nx = r_idx + 2'd1;
        w_tick = r_idx == 2'd3;
        w_fstart = w_tick;
      end
    endcase
    if (!bus.enable) begin
      w_next = S_IDLE;
      w_cnt_nx = 16'd0;
      w_idx_nx = 2'd0;
      w_fstart = 1'b0;
      w_lit = 1'b0;
      w_tick = 1'b0;
    end
  end
  // state, buffers and registered display outputs; anode, segments and dp change on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx <= 2'd0;
      r_cnt <= 16'd0;
      r_act_dig <= 16'd0;
      r_act_dp <= 4'd0;
      r_act_lz <= 1'b0;
      r_pen_dig <= 16'd0;
      r_pen_dp <= 4'd0;
      r_pen_lz <= 1'b0;
      r_pending <= 1'b0;
      r_seg <= 7'd0;
      r_dp <= 1'b0;
      r_an <= 4'hf;
      r_tick <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx <= w_idx_nx;
      r_cnt <= w_cnt_nx;
      r_tick <= w_tick;
      r_an <= w_next != S_SHOW ? 4'hf : w_lit ? ~(4'b0001 << r_idx) : r_an;
      r_seg <= w_next != S_SHOW ? 7'd0 : w_lit ? (w_blank ? 7'd0 : bus.seg_dec) : r_seg;
      r_dp <= w_next != S_SHOW ? 1'b0 : w_lit ? r_act_dp[r_idx] : r_dp;
      if (w_fstart && r_pending) begin
        r_act_dig <= r_pen_dig;
        r_act_dp <= r_pen_dp;
        r_act_lz <= r_pen_lz;
      end
      if (bus.load) begin
        r_pen_dig <= bus.digits_in;
        r_pen_dp <= bus.dp_in;
        r_pen_lz <= bus.lz_en;
      end
      r_pending <= bus.load | (r_pending & ~w_fstart);
    end
  end
endmodule
